// File: rtl/weight_loader.sv
// weight_loader: packs a valid/ready element stream into WIDTH-bit words and writes them
// to consecutive memory_bank addresses. Optional checksum: define WEIGHT_LOADER_CHECKSUM_EN.
module weight_loader #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 256,
    parameter int ELEM_W = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AW-1:0]     base_addr,
    input  logic [AW:0]       num_words,
    input  logic              s_valid,
    input  logic [ELEM_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              mem_we,
    output logic [AW-1:0]     mem_waddr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       checksum
);

    localparam int LANES = WIDTH / ELEM_W;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
    localparam logic [LW-1:0] LANE_ONE  = LW'(1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [AW:0]   WORD_ONE  = (AW+1)'(1);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t            state;
    logic [LW-1:0]     lane_cnt;
    logic [AW:0]       word_cnt;
    logic [AW:0]       nwords;
    logic [AW-1:0]     addr;
    logic [WIDTH-1:0]  word_buf;
    logic [WIDTH-1:0]  word_next;
    logic              accept;
    logic              lane_full;
    logic              final_word;
    logic              word_end;

    assign accept     = s_valid && s_ready;
    assign lane_full  = (lane_cnt == LAST_LANE);
    assign final_word = ((word_cnt + WORD_ONE) == nwords);
    assign word_end   = accept && (lane_full || s_last);

    // Lanes above the current one are still zero in word_buf, which gives
    // the zero padding for a word cut short by an early s_last.
    always_comb begin
        word_next = word_buf;
        word_next[lane_cnt*ELEM_W +: ELEM_W] = s_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lane_cnt  <= '0;
            word_cnt  <= '0;
            nwords    <= '0;
            addr      <= '0;
            word_buf  <= '0;
            s_ready   <= 1'b0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        err <= 1'b0;
                        if (num_words != '0) begin
                            nwords   <= num_words;
                            addr     <= base_addr;
                            word_cnt <= '0;
                            lane_cnt <= '0;
                            word_buf <= '0;
                            s_ready  <= 1'b1;
                            busy     <= 1'b1;
                            state    <= LOAD;
                        end else begin
                            // Empty load still takes the DRAIN cycle so done keeps its 2-cycle latency.
                            busy  <= 1'b1;
                            state <= DRAIN;
                        end
                    end
                end
                LOAD: begin
                    if (word_end) begin
                        mem_we    <= 1'b1;
                        mem_waddr <= addr;
                        mem_wdata <= word_next;
                        addr      <= (addr == LAST_ADDR) ? '0 : addr + ADDR_ONE;
                        word_cnt  <= word_cnt + WORD_ONE;
                        lane_cnt  <= '0;
                        word_buf  <= '0;
                        if (final_word || s_last) begin
                            err     <= !(final_word && lane_full);
                            s_ready <= 1'b0;
                            state   <= DRAIN;
                        end
                    end else if (accept) begin
                        word_buf <= word_next;
                        lane_cnt <= lane_cnt + LANE_ONE;
                    end
                end
                DRAIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    s_ready <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [15:0] csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (state == IDLE && start) begin
            csum <= '0;
        end else if (accept) begin
            csum <= csum + 16'(s_data);
        end
    end

    assign checksum = csum;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Bench for weight_loader: table-driven directed loads, reset abort, and random loads
// with gapped s_valid checked against a word-packing reference model.
module tb_weight_loader;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 256;
    localparam int ELEM_W = 8;
    localparam int AW     = 8;
    localparam int LANES  = WIDTH / ELEM_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [AW-1:0]     base_addr = '0;
    logic [AW:0]       num_words = '0;
    logic              s_valid = 1'b0;
    logic [ELEM_W-1:0] s_data = '0;
    logic              s_last = 1'b0;
    logic              s_ready;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [15:0]       checksum;

    weight_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ELEM_W(ELEM_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .num_words(num_words), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err), .checksum(checksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] d;
        int               c;
    } wr_t;

    typedef struct {
        logic [AW-1:0] base;
        int            nw;
        int            n;
        logic [7:0]    first;
        logic [7:0]    step;
        int            exp_nwr;
        logic [AW-1:0] exp_laddr;
        logic [31:0]   exp_ldata;
        bit            exp_err;
        logic [15:0]   exp_csum;
    } vec_t;

    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    wr_t        wr_q[$];
    logic [7:0] stim_q[$];
    int         acc_last, done_cyc, done_cnt, start_c, ready_extra;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we) wr_q.push_back('{mem_waddr, mem_wdata, cyc});
        if (s_valid && s_ready) acc_last = cyc;
        if (done) begin
            done_cyc = cyc;
            done_cnt++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".s_ready"}, 64'(s_ready), 64'(0));
        chk({tag, ".mem_we"}, 64'(mem_we), 64'(0));
        chk({tag, ".busy"}, 64'(busy), 64'(0));
        chk({tag, ".done"}, 64'(done), 64'(0));
        chk({tag, ".err"}, 64'(err), 64'(0));
        chk({tag, ".mem_waddr"}, 64'(mem_waddr), 64'(0));
        chk({tag, ".mem_wdata"}, 64'(mem_wdata), 64'(0));
        chk({tag, ".checksum"}, 64'(checksum), 64'(0));
    endtask

    // Drives one complete load: start pulse, the elements of stim_q, then a
    // tail that keeps offering data to show nothing more is accepted.
    task automatic run_load(input logic [AW-1:0] base, input int nw, input bit use_last,
                            input int vpct, input bit poke);
        int idx;
        int guard;
        bit acc;
        wr_q.delete();
        done_cnt = 0;
        done_cyc = -1;
        acc_last = -1;
        ready_extra = 0;
        base_addr = base;
        num_words = (AW+1)'(nw);
        start = 1'b1;
        start_c = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0;
        guard = 0;
        while (idx < stim_q.size() && guard < 4000) begin
            s_valid = (int'($urandom_range(99)) < vpct);
            s_data = stim_q[idx];
            s_last = use_last && (idx == stim_q.size() - 1);
            start = poke && ($urandom_range(3) == 0);
            if (start) begin
                base_addr = AW'($urandom);
                num_words = (AW+1)'(1);
            end
            acc = s_valid && s_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            guard++;
        end
        chk("stream_consumed", 64'(idx), 64'(stim_q.size()));
        start = 1'b0;
        s_last = 1'b0;
        s_data = 8'h5A;
        for (int k = 0; k < 6; k++) begin
            s_valid = 1'b1;
            if (s_ready) ready_extra++;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
    endtask

    // Reference: element k of the stream lands in word k/LANES, lane k%LANES;
    // only the first min(stream length, nw*LANES) elements are taken.
    task automatic check_model(input string tag, input logic [AW-1:0] base, input int nw);
        int total, consumed, nexp;
        logic [WIDTH-1:0] w;
        logic [AW-1:0] a;
        logic [15:0] sum;
        total = nw * LANES;
        consumed = (stim_q.size() < total) ? stim_q.size() : total;
        nexp = (consumed + LANES - 1) / LANES;
        sum = '0;
        for (int i = 0; i < consumed; i++) sum = sum + 16'(stim_q[i]);
        chk({tag, ".nwrites"}, 64'(wr_q.size()), 64'(nexp));
        for (int i = 0; i < nexp && i < wr_q.size(); i++) begin
            w = '0;
            for (int j = 0; j < LANES; j++)
                if (i * LANES + j < consumed) w[j*ELEM_W +: ELEM_W] = stim_q[i*LANES + j];
            a = AW'((int'(base) + i) % DEPTH);
            chk($sformatf("%s.addr%0d", tag, i), 64'(wr_q[i].a), 64'(a));
            chk($sformatf("%s.data%0d", tag, i), 64'(wr_q[i].d), 64'(w));
        end
        chk({tag, ".err"}, 64'(err), 64'(consumed < total));
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        chk({tag, ".checksum"}, 64'(checksum), 64'(sum));
`else
        chk({tag, ".checksum"}, 64'(checksum), 64'(0));
`endif
        if (nexp > 0 && wr_q.size() > 0) begin
            chk({tag, ".write_lat"}, 64'(wr_q[wr_q.size()-1].c), 64'(acc_last + 1));
            chk({tag, ".done_lat"}, 64'(done_cyc), 64'(acc_last + 2));
        end else begin
            chk({tag, ".done_lat"}, 64'(done_cyc), 64'(start_c + 2));
        end
        chk({tag, ".done_cnt"}, 64'(done_cnt), 64'(1));
        chk({tag, ".ready_after"}, 64'(ready_extra), 64'(0));
        chk({tag, ".busy_idle"}, 64'(busy), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        vecs[0] = '{8'h10, 2, 8,  8'h01, 8'h01, 2, 8'h11, 32'h08070605, 1'b0, 16'h0024};
        vecs[1] = '{8'hFE, 3, 12, 8'h01, 8'h01, 3, 8'h00, 32'h0C0B0A09, 1'b0, 16'h004E};
        vecs[2] = '{8'h20, 2, 5,  8'hAA, 8'h11, 2, 8'h21, 32'h000000EE, 1'b1, 16'h03FC};
        vecs[3] = '{8'h30, 3, 4,  8'h10, 8'h01, 1, 8'h30, 32'h13121110, 1'b1, 16'h0046};
        vecs[4] = '{8'hFF, 1, 4,  8'hF0, 8'h01, 1, 8'hFF, 32'hF3F2F1F0, 1'b0, 16'h03C6};
        vecs[5] = '{8'h05, 0, 0,  8'h00, 8'h00, 0, 8'h00, 32'h00000000, 1'b0, 16'h0000};

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 6; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            stim_q.delete();
            for (int i = 0; i < vecs[v].n; i++) stim_q.push_back(8'(vecs[v].first + i * vecs[v].step));
            run_load(vecs[v].base, vecs[v].nw, 1'b1, 100, 1'b0);
            check_model(tag, vecs[v].base, vecs[v].nw);
            chk({tag, ".tab_nwr"}, 64'(wr_q.size()), 64'(vecs[v].exp_nwr));
            if (wr_q.size() > 0) begin
                chk({tag, ".tab_laddr"}, 64'(wr_q[wr_q.size()-1].a), 64'(vecs[v].exp_laddr));
                chk({tag, ".tab_ldata"}, 64'(wr_q[wr_q.size()-1].d), 64'(vecs[v].exp_ldata));
            end
            chk({tag, ".tab_err"}, 64'(err), 64'(vecs[v].exp_err));
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            chk({tag, ".tab_csum"}, 64'(checksum), 64'(vecs[v].exp_csum));
`endif
        end

        // Same data as the back-to-back case, with gapped s_valid and stray start pulses.
        stim_q.delete();
        for (int i = 0; i < 16; i++) stim_q.push_back(8'(i + 1));
        run_load(8'h10, 4, 1'b1, 50, 1'b1);
        check_model("gapped", 8'h10, 4);

        // Reset in the middle of the second word.
        base_addr = 8'h40;
        num_words = 9'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wr_q.delete();
        for (int k = 0; k < 6; k++) begin
            s_valid = 1'b1;
            s_data = 8'(k + 1);
            s_last = 1'b0;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        chk("midreset.nwrites", 64'(wr_q.size()), 64'(1));
        if (wr_q.size() > 0) begin
            chk("midreset.addr0", 64'(wr_q[0].a), 64'(8'h40));
            chk("midreset.data0", 64'(wr_q[0].d), 64'(32'h04030201));
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midreset.no_more_writes", 64'(wr_q.size()), 64'(1));
        @(posedge clk); #1;
        stim_q.delete();
        for (int i = 0; i < 8; i++) stim_q.push_back(8'(i + 1));
        run_load(8'h40, 2, 1'b1, 100, 1'b0);
        check_model("reload", 8'h40, 2);

        for (int r = 0; r < 10; r++) begin
            int nw, n;
            bit early, use_last;
            logic [AW-1:0] base;
            nw = int'($urandom_range(8, 1));
            base = AW'($urandom);
            early = ($urandom_range(2) == 0);
            n = early ? int'($urandom_range(nw * LANES - 1, 1)) : nw * LANES;
            use_last = early ? 1'b1 : 1'($urandom_range(1));
            stim_q.delete();
            for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom));
            run_load(base, nw, use_last, 50, 1'b1);
            check_model($sformatf("rand%0d", r), base, nw);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
